// File: rtl/led_scan_pkg.sv
// Shared constants and state encoding for the 8x8 LED column-scan controller.
package led_scan_pkg;
  localparam int NUM_COLS = 8;
  localparam int COL_W    = 3;
  localparam int ROW_W    = 8;

  typedef enum logic [1:0] {
    OFF,
    BLANKING,
    DRIVE
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/led_scan_ctrl_if.sv
// Frame-buffer write/swap controls and column/row drive outputs of the scan controller.
interface led_scan_ctrl_if;
  import led_scan_pkg::*;

  logic             ENABLE;
  logic             WR_EN;
  logic [COL_W-1:0] WR_ADDR;
  logic [ROW_W-1:0] WR_DATA;
  logic             SWAP_REQ;
  logic             SWAP_ACK;
  logic             SWAP_PENDING;
  logic [COL_W-1:0] SELECT;
  logic [ROW_W-1:0] ROW;
  logic             FRAME_START;

  modport master (
    output ENABLE, WR_EN, WR_ADDR, WR_DATA, SWAP_REQ,
    input  SWAP_ACK, SWAP_PENDING, SELECT, ROW, FRAME_START
  );

  modport slave (
    input  ENABLE, WR_EN, WR_ADDR, WR_DATA, SWAP_REQ,
    output SWAP_ACK, SWAP_PENDING, SELECT, ROW, FRAME_START
  );
endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, where it holds.
module scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/led_scan_ctrl.sv
// 8x8 LED column scanner: blank gap then dwell per column, double-buffered frame data.
// All outputs registered; a swap request is applied at the frame boundary (or at once when idle).
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic            clk,
  input  logic            reset,
  led_scan_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(max2(DWELL, BLANK));
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             fs_d;
  logic             tc;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             front_q;
  logic             pending_q, pending_d;
  logic             swap_do;
  logic [ROW_W-1:0] mem [2][NUM_COLS];

  scan_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fs_d    = 1'b0;
    if (!bus.ENABLE) begin
      state_d = OFF;
      col_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = BLANKING;
          col_d   = '0;
          fs_d    = 1'b1;
        end
        BLANKING: begin
          if (tc) state_d = DRIVE;
        end
        DRIVE: begin
          if (tc) begin
            state_d = BLANKING;
            col_d   = col_q + COL_W'(1);
            fs_d    = (col_q == LAST_COL);
          end
        end
        default: begin
          state_d = OFF;
          col_d   = '0;
        end
      endcase
    end

    // Swap only at the frame boundary, or right away while idle.
    swap_do   = ((state_q == DRIVE) && tc && (col_q == LAST_COL) && (pending_q || bus.SWAP_REQ))
              || ((state_q == OFF) && pending_q);
    pending_d = swap_do ? 1'b0 : (pending_q | bus.SWAP_REQ);

    load     = (state_d != state_q);
    load_val = (state_d == DRIVE)    ? DWELL_LD :
               (state_d == BLANKING) ? BLANK_LD : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= OFF;
      col_q           <= '0;
      front_q         <= 1'b0;
      pending_q       <= 1'b0;
      bus.SELECT      <= '0;
      bus.ROW         <= '0;
      bus.SWAP_ACK    <= 1'b0;
      bus.FRAME_START <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      pending_q       <= pending_d;
      if (swap_do) front_q <= ~front_q;
      bus.SELECT      <= col_d;
      // Front pointer never flips on a transition into DRIVE, so front_q is the right bank.
      bus.ROW         <= (state_d == DRIVE) ? mem[front_q][col_d] : '0;
      bus.SWAP_ACK    <= swap_do;
      bus.FRAME_START <= fs_d;
    end
  end

  // Writes land in the pre-swap back bank, which becomes front if a swap coincides.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          mem[b][c] <= '0;
        end
      end
    end else if (bus.WR_EN) begin
      mem[~front_q][bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  assign bus.SWAP_PENDING = pending_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomised scoreboard bench: a frame-arithmetic model predicts every output cycle.
module tb_led_scan_ctrl;
  import led_scan_pkg::*;

  localparam int DW    = 4;
  localparam int BL    = 1;
  localparam int P     = DW + BL;
  localparam int FRAME = NUM_COLS * P;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_scan_ctrl_if bus();

  led_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] row;
    logic       fs;
    logic       ack;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   tests   = 0;
  int   fails   = 0;
  bit   started = 1'b0;

  // Reference model: scan position within the frame plus two plain buffer arrays.
  bit         m_scan;
  int         m_pos;
  bit         m_pend;
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];

  task automatic cycle(input bit r, input bit en, input bit wr,
                       input logic [2:0] addr, input logic [7:0] data, input bit req);
    exp_t       e;
    bit         swap;
    logic [7:0] tmp;
    @(negedge clk);
    reset        = r;
    bus.ENABLE   = en;
    bus.WR_EN    = wr;
    bus.WR_ADDR  = addr;
    bus.WR_DATA  = data;
    bus.SWAP_REQ = req;
    if (r) begin
      m_scan = 1'b0;
      m_pos  = 0;
      m_pend = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_front[i] = '0;
        m_back[i]  = '0;
      end
      e = '0;
    end else begin
      swap = (m_scan && m_pos == FRAME - 1 && (m_pend || req)) || (!m_scan && m_pend);
      if (wr) m_back[addr] = data;
      if (swap) begin
        for (int i = 0; i < 8; i++) begin
          tmp        = m_front[i];
          m_front[i] = m_back[i];
          m_back[i]  = tmp;
        end
      end
      m_pend = !swap && (m_pend || req);
      if (!en) begin
        m_scan = 1'b0;
        m_pos  = 0;
      end else if (!m_scan) begin
        m_scan = 1'b1;
        m_pos  = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      e.sel  = m_scan ? 3'(m_pos / P) : 3'd0;
      e.row  = (m_scan && (m_pos % P) >= BL) ? m_front[m_pos / P] : 8'h00;
      e.fs   = m_scan && (m_pos == 0);
      e.ack  = swap;
      e.pend = m_pend;
    end
    started = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        if (started) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty at %0t: no expected entry queued", $time);
        end
      end else begin
        e = exp_q.pop_front();
        g = {bus.SELECT, bus.ROW, bus.FRAME_START, bus.SWAP_ACK, bus.SWAP_PENDING};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs at %0t: got sel=%0d row=%h fs=%b ack=%b pend=%b, expected sel=%0d row=%h fs=%b ack=%b pend=%b",
                   $time, g.sel, g.row, g.fs, g.ack, g.pend, e.sel, e.row, e.fs, e.ack, e.pend);
        end
      end
    end
  end

  initial begin
    bit         r, en, wr, req;
    logic [2:0] addr;
    logic [7:0] data;
    int         off_left;

    reset        = 1'b1;
    bus.ENABLE   = 1'b0;
    bus.WR_EN    = 1'b0;
    bus.WR_ADDR  = '0;
    bus.WR_DATA  = '0;
    bus.SWAP_REQ = 1'b0;
    m_scan = 1'b0;
    m_pos  = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end

    repeat (3) cycle(1, 0, 0, 3'd0, 8'h00, 0);
    repeat (4) cycle(0, 0, 0, 3'd0, 8'h00, 0);

    // First frame of zeros, then load back[3] and request a swap mid-frame.
    repeat (FRAME + 2 * P + 2) cycle(0, 1, 0, 3'd0, 8'h00, 0);
    cycle(0, 1, 1, 3'd3, 8'hA5, 0);
    cycle(0, 1, 0, 3'd0, 8'h00, 1);
    repeat (2 * FRAME) cycle(0, 1, 0, 3'd0, 8'h00, 0);

    // Idle swap: request while disabled, then resume.
    repeat (3) cycle(0, 0, 0, 3'd0, 8'h00, 0);
    cycle(0, 0, 0, 3'd0, 8'h00, 1);
    repeat (3) cycle(0, 0, 0, 3'd0, 8'h00, 0);
    repeat (FRAME + 5) cycle(0, 1, 0, 3'd0, 8'h00, 0);

    off_left = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 799) == 0);
      if (off_left > 0) begin
        en = 1'b0;
        off_left--;
      end else if ($urandom_range(0, 249) == 0) begin
        en       = 1'b0;
        off_left = $urandom_range(1, 6);
      end else begin
        en = 1'b1;
      end
      wr   = ($urandom_range(0, 5) == 0);
      req  = ($urandom_range(0, 59) == 0);
      addr = 3'($urandom_range(0, 7));
      data = 8'($urandom_range(0, 255));
      if (!en) req = req || ($urandom_range(0, 3) == 0);
      if (m_scan && m_pos == FRAME - 1) begin
        wr  = ($urandom_range(0, 1) == 1);
        req = ($urandom_range(0, 1) == 1);
      end
      cycle(r, en, wr, addr, data, req);
    end

    repeat (2) cycle(0, 1, 0, 3'd0, 8'h00, 0);
    @(posedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
